// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Receive end of the packet-serial link. Deserialises NUM_WORDS framed UART
// words (start bit, BITS_PER_WORD data bits LSB-first, at least one stop bit)
// and presents them as a single beat on a valid/ready master interface.
// Word 0 on the line lands in m_data[0].
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   m_data     received beat, word n is the n-th word on the line
//   m_valid    beat available, held until accepted
//   m_ready    sink accepts the beat
//   frame_err  one-cycle pulse on a bad start or stop bit
//   overrun    one-cycle pulse when a completed beat is dropped because
//              the previous one is still pending
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter  int CLOCKS_PER_PULSE = 4,
  parameter  int BITS_PER_WORD    = 8,
  parameter  int W_OUT            = 24,
  localparam int NUM_WORDS        = W_OUT / BITS_PER_WORD
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         rx,
  output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]      m_data,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic                                         frame_err,
  output logic                                         overrun
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(BITS_PER_WORD + 1);
  localparam int WW = $clog2(NUM_WORDS + 1);

  localparam logic [CW-1:0] CLK_LAST   = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] CLK_MID    = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_WORD - 1);
  localparam logic [WW-1:0] WORDS_FULL = WW'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                                      state_r;
  logic                                        rx_meta_r;
  logic                                        rx_sync_r;
  logic                                        rx_prev_r;
  logic [CW-1:0]                               c_clocks_r;
  logic [BW-1:0]                               c_bits_r;
  logic [WW-1:0]                               c_words_r;
  logic [BITS_PER_WORD-1:0]                    shift_r;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]     words_r;
  logic                                        beat_done_s;

  // A beat is complete once every word slot holds a good word.
  assign beat_done_s = (c_words_r == WORDS_FULL);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  // All three idle high so a quiet line never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Framing FSM, word assembly and beat hand-off to the master interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      c_clocks_r <= {CW{1'b0}};
      c_bits_r   <= {BW{1'b0}};
      c_words_r  <= {WW{1'b0}};
      shift_r    <= {BITS_PER_WORD{1'b0}};
      words_r    <= {(NUM_WORDS*BITS_PER_WORD){1'b0}};
      m_data     <= {(NUM_WORDS*BITS_PER_WORD){1'b0}};
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Completion is seen in the cycle after the last stop sample, when the
      // FSM is already back in IDLE, so it never collides with a STOP update
      // of c_words_r. A handshake in this same cycle frees the slot, which is
      // why only valid-without-ready counts as an overrun.
      if (beat_done_s) begin
        c_words_r <= {WW{1'b0}};
        if (m_valid && !m_ready) begin
          overrun <= 1'b1;
        end else begin
          m_data  <= words_r;
          m_valid <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end else begin
        m_valid <= m_valid;
      end

      case (state_r)
        IDLE: begin
          // Only a 1->0 transition starts a frame; a line stuck low
          // after a framing error stays here.
          if (rx_prev_r && !rx_sync_r) begin
            c_clocks_r <= {CW{1'b0}};
            state_r    <= START;
          end else begin
            state_r <= IDLE;
          end
        end

        START: begin
          if (c_clocks_r == CLK_MID) begin
            if (rx_sync_r) begin
              // High again by mid-bit: a glitch, not a start bit.
              state_r <= IDLE;
            end else begin
              c_clocks_r <= {CW{1'b0}};
              c_bits_r   <= {BW{1'b0}};
              state_r    <= DATA;
            end
          end else begin
            c_clocks_r <= c_clocks_r + CW'(1);
          end
        end

        DATA: begin
          // Counting a full period from mid-start lands every sample
          // in the middle of its data bit.
          if (c_clocks_r == CLK_LAST) begin
            c_clocks_r <= {CW{1'b0}};
            shift_r    <= {rx_sync_r, shift_r[BITS_PER_WORD-1:1]};
            c_bits_r   <= c_bits_r + BW'(1);
            if (c_bits_r == BIT_LAST) begin
              state_r <= STOP;
            end else begin
              state_r <= DATA;
            end
          end else begin
            c_clocks_r <= c_clocks_r + CW'(1);
          end
        end

        STOP: begin
          if (c_clocks_r == CLK_LAST) begin
            c_clocks_r <= {CW{1'b0}};
            state_r    <= IDLE;
            if (rx_sync_r) begin
              for (int i = 0; i < NUM_WORDS; i++) begin
                if (c_words_r == WW'(i)) begin
                  words_r[i] <= shift_r;
                end
              end
              c_words_r <= c_words_r + WW'(1);
            end else begin
              // Bad stop bit: the whole partial beat is untrustworthy.
              frame_err <= 1'b1;
              c_words_r <= {WW{1'b0}};
            end
          end else begin
            c_clocks_r <= c_clocks_r + CW'(1);
          end
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx: drives framed words on rx, keeps a queue of
// expected beats and compares each beat as it is handed off on m_valid/m_ready.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPP = 4;
  localparam int BPW = 8;
  localparam int WO  = 24;

  logic            clk;
  logic            rst;
  logic            rx;
  logic [2:0][7:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic            frame_err;
  logic            overrun;

  int total;
  int bad;
  int hs_cnt;
  int fe_cnt;
  int ov_cnt;
  logic mv_smp;
  logic [23:0] exp_q[$];

  uart_rx #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (BPW),
    .W_OUT           (WO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    logic [23:0] e;
    @(negedge clk);
    mv_smp = m_valid;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (m_valid && m_ready) begin
      hs_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL hs_unexpected: observed beat=%0h expected no beat", m_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", {8'h00, m_data}, {8'h00, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPP) tick();
  endtask

  task automatic send_word(input logic [7:0] d, input logic first_stop, input int nstop);
    send_bit(1'b0);
    for (int i = 0; i < BPW; i++) send_bit(d[i]);
    send_bit(first_stop);
    for (int i = 1; i < nstop; i++) send_bit(1'b1);
  endtask

  task automatic send_beat(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int nstop);
    send_word(w0, 1'b1, nstop);
    send_word(w1, 1'b1, nstop);
    send_word(w2, 1'b1, nstop);
  endtask

  initial begin
    int   waited;
    logic stable;
    total   = 0;
    bad     = 0;
    hs_cnt  = 0;
    fe_cnt  = 0;
    ov_cnt  = 0;
    mv_smp  = 1'b0;
    rst     = 1'b1;
    rx      = 1'b1;
    m_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid",   {31'd0, m_valid},   32'd0);
    check("rst_m_data",    {8'h00, m_data},    32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun",   {31'd0, overrun},   32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Single beat with the sink ready
    exp_q.push_back(24'hFF3CA5);
    send_beat(8'hA5, 8'h3C, 8'hFF, 4);
    repeat (10) tick();
    check("single_hs",      hs_cnt, 32'd1);
    check("single_fe",      fe_cnt, 32'd0);
    check("single_ov",      ov_cnt, 32'd0);
    check("single_word0",   {24'h0, m_data[0]}, 32'h0000_00A5);

    // Backpressure: beat must be held stable for 100 cycles
    m_ready = 1'b0;
    exp_q.push_back(24'hFF3CA5);
    send_beat(8'hA5, 8'h3C, 8'hFF, 4);
    waited = 0;
    while (!mv_smp && waited < 50) begin
      tick();
      waited++;
    end
    check("bp_valid_seen", {31'd0, mv_smp}, 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mv_smp !== 1'b1 || m_data !== 24'hFF3CA5) stable = 1'b0;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);

    // Overrun: a second beat while the first is still pending
    send_beat(8'h01, 8'h02, 8'h03, 4);
    repeat (5) tick();
    check("ovr_count",  ov_cnt, 32'd1);
    check("ovr_data",   {8'h00, m_data}, 32'h00FF_3CA5);
    check("ovr_valid",  {31'd0, mv_smp}, 32'd1);
    check("ovr_no_hs",  hs_cnt, 32'd1);

    // Release: handshake, then m_valid low on the following cycle
    m_ready = 1'b1;
    tick();
    tick();
    check("bp_hs",         hs_cnt, 32'd2);
    check("bp_valid_low",  {31'd0, mv_smp}, 32'd0);

    // Framing: word 2's stop bit is 0
    send_word(8'h44, 1'b1, 4);
    send_word(8'h55, 1'b1, 4);
    send_word(8'h66, 1'b0, 4);
    repeat (10) tick();
    check("frm_fe",  fe_cnt, 32'd1);
    check("frm_hs",  hs_cnt, 32'd2);
    exp_q.push_back(24'h332211);
    send_beat(8'h11, 8'h22, 8'h33, 4);
    repeat (10) tick();
    check("frm_next_hs", hs_cnt, 32'd3);
    check("frm_fe_once", fe_cnt, 32'd1);

    // Glitch: a single-cycle low pulse while idle
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (20) tick();
    check("glitch_fe", fe_cnt, 32'd1);
    check("glitch_hs", hs_cnt, 32'd3);

    // Back-to-back words with one stop bit each
    exp_q.push_back(24'h815AC3);
    send_beat(8'hC3, 8'h5A, 8'h81, 1);
    repeat (10) tick();
    check("b2b_hs", hs_cnt, 32'd4);
    check("b2b_fe", fe_cnt, 32'd0 + 32'd1);

    // Reset in the middle of word 1's data bits
    send_word(8'h99, 1'b1, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check("mid_rst_m_data",    {8'h00, m_data},    32'd0);
    check("mid_rst_m_valid",   {31'd0, m_valid},   32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("mid_rst_overrun",   {31'd0, overrun},   32'd0);
    @(posedge clk);
    #1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    exp_q.push_back(24'h563412);
    send_beat(8'h12, 8'h34, 8'h56, 2);
    repeat (10) tick();
    check("post_rst_hs",  hs_cnt, 32'd5);
    check("final_fe",     fe_cnt, 32'd1);
    check("final_ov",     ov_cnt, 32'd1);
    check("queue_empty",  exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
